tm_mac_seq: RTL and testbench
=============================

Name: tm_mac_seq

Overview:
Sequential, multi-lane temporal multiply-accumulate engine. Each lane has its own activation A; all lanes share one broadcast weight W. The product is formed by adding ±A once per cycle for |W| cycles, and the sums accumulate over a vector of (A,W) pairs until a flagged last pair. The result is then presented on a valid/ready output. It succeeds the combinational temporal multiplier: it adds a clock, handshakes, accumulation, lanes and unsigned-W support.

Parameters:
DW, 8, operand width of A and W
NLANE, 4, number of parallel A lanes sharing W
ACCW, 32, accumulator width per lane; must satisfy ACCW >= 2*DW+1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  engine can accept a pair
in_a  input  NLANE*DW  lane activations, lane i at bits [i*DW +: DW]
a_signed  input  1  A lanes are two's complement when 1
in_w  input  DW  shared weight
w_signed  input  1  W is two's complement when 1
in_last  input  1  this pair closes the dot product
out_valid  output  1  accumulators valid
out_ready  input  1  consumer takes result
out_acc  output  NLANE*ACCW  per-lane accumulated sums, lane i at [i*ACCW +: ACCW]
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state and values: state=IDLE, in_ready=1, out_valid=0, busy=0, all accumulators 0, counter 0.
- Reset mid-operation: reset asserted in any state aborts the operation and discards partial sums.
- in_ready: equals (state==IDLE).
- Operand capture: on in_valid&&in_ready, latch A lanes, a_signed and last.
  - wneg = w_signed & W[DW-1].
  - wmag = wneg ? (2^DW - W) : W, held unsigned in DW bits; W=-2^(DW-1) gives 2^(DW-1).
  - Extension: ext(A) = a_signed ? sign-extend A to ACCW : zero-extend A to ACCW.
- IDLE:
  - On accept with wmag!=0, load cnt=wmag and go to MUL.
  - On accept with wmag==0, no MUL cycles; go to OUT if last, else stay IDLE.
- MUL: each cycle, every lane does acc += wneg ? -ext(A) : ext(A), and cnt decrements. On the cycle where cnt==1, after the final add, go to OUT if last, else IDLE.
- OUT: out_valid=1. out_acc and all state are held stable while out_ready=0. On out_valid&&out_ready, clear the accumulators to 0 and go to IDLE.
- Timing:
  - A pair with magnitude m occupies m MUL cycles.
  - From acceptance of the last pair to out_valid is m+1 cycles.
  - The next pair can be accepted the cycle after leaving MUL or OUT.
- Overflow: accumulation wraps modulo 2^ACCW unless TM_SAT_EN is defined.
- out_acc is the accumulator registers directly; it is not gated by out_valid.

Optional Feature:
- Macro: TM_SAT_EN.
- When defined: each per-cycle add saturates to the signed ACCW range [-2^(ACCW-1), 2^(ACCW-1)-1]. Detection uses one extra guard bit on the add.
- When undefined: plain two's-complement wrap-around, no guard logic.

Decomposition:
- Package tm_pkg:
  - state enum {IDLE, MUL, OUT}
  - function tm_abs (magnitude plus negative flag)
  - function tm_ext (signed/unsigned extension to ACCW)
- Sub-module tm_lane: one accumulator register with clear, ±A add and optional saturation. It is instantiated NLANE times in a generate loop; the FSM and counter stay in tm_mac_seq.

Test Plan:
1. Single pair, signed, W=5 signed, last=1, A={3,-2,127,-128} -> exactly 5 MUL cycles; out_valid 6 cycles after accept; out_acc={15,-10,635,-640}.
2. W=0x80 signed (-128), A lanes=255 unsigned, last=1 -> 128 MUL cycles; every lane out_acc=-32640.
3. Pair W=0 last=0, then W=2 signed last=1, A=7 signed -> first pair accepted with in_ready staying 1 and no MUL cycles; out_acc=14.
4. out_ready held low 10 cycles in OUT -> out_valid=1, out_acc stable, in_ready=0; after handshake the next dot product (W=1, A=4) yields 4, not accumulated onto the old result.
5. rst pulsed on 3rd MUL cycle of W=100 -> next cycle in_ready=1, busy=0, out_valid=0, accumulators 0; fresh pair W=3, A=-5 signed yields -15.
6. ACCW=16, three pairs A=127 signed, W=127 signed, last on third -> with TM_SAT_EN out_acc=32767; without it out_acc=-17149.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared types and helpers for the temporal multiply-accumulate engine.
// Helpers work on a fixed 64-bit carrier so that any DW/ACCW up to 64 can use them.
package tm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_OUT  = 2'd2
    } tm_state_e;

    localparam int TM_MAXW = 64;

    typedef struct packed {
        logic               neg;
        logic [TM_MAXW-1:0] mag;
    } tm_abs_t;

    // Magnitude of the low dw bits of w; the most negative signed value maps to 2^(dw-1).
    function automatic tm_abs_t tm_abs(input logic [TM_MAXW-1:0] w,
                                       input int dw,
                                       input logic is_signed);
        logic [TM_MAXW-1:0] mask;
        tm_abs_t            r;
        mask  = (TM_MAXW'(1) << dw) - TM_MAXW'(1);
        r.neg = is_signed & w[dw-1];
        r.mag = r.neg ? ((~w + TM_MAXW'(1)) & mask) : (w & mask);
        return r;
    endfunction

    function automatic logic [TM_MAXW-1:0] tm_ext(input logic [TM_MAXW-1:0] a,
                                                  input int dw,
                                                  input logic is_signed);
        logic [TM_MAXW-1:0] r;
        for (int i = 0; i < TM_MAXW; i++) begin
            r[i] = (i < dw) ? a[i] : (is_signed & a[dw-1]);
        end
        return r;
    endfunction

endpackage

// File: rtl/tm_lane.sv
// One accumulator lane: clear, add/subtract the captured activation per MUL cycle.
// Define TM_SAT_EN to saturate each add to the signed ACCW range instead of wrapping.
module tm_lane #(
    parameter int ACCW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            add_en_i,
    input  logic            neg_i,
    input  logic [ACCW-1:0] a_ext_i,
    output logic [ACCW-1:0] acc_o
);

    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] acc_d;
    logic [ACCW-1:0] acc_sum;

`ifdef TM_SAT_EN
    logic [ACCW:0] sum_g;

    // Guard bit disagreeing with the sign bit means the true result left the signed range.
    always_comb begin
        sum_g = neg_i ? ({acc_q[ACCW-1], acc_q} - {a_ext_i[ACCW-1], a_ext_i})
                      : ({acc_q[ACCW-1], acc_q} + {a_ext_i[ACCW-1], a_ext_i});
        if (sum_g[ACCW] != sum_g[ACCW-1]) begin
            acc_sum = sum_g[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        end else begin
            acc_sum = sum_g[ACCW-1:0];
        end
    end
`else
    assign acc_sum = neg_i ? (acc_q - a_ext_i) : (acc_q + a_ext_i);
`endif

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_en_i) begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/tm_mac_seq.sv
// Multi-lane temporal MAC: each pair adds +/-A per lane for |W| cycles, accumulating until a last pair.
// Optional TM_SAT_EN (see tm_lane) switches lane accumulation from wrap-around to saturation.
module tm_mac_seq
    import tm_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NLANE = 4,
    parameter int ACCW  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NLANE*DW-1:0]   in_a,
    input  logic                  a_signed,
    input  logic [DW-1:0]         in_w,
    input  logic                  w_signed,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NLANE*ACCW-1:0] out_acc,
    output logic                  busy
);

    tm_state_e             state_q, state_d;
    logic [DW-1:0]         cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  last_q, last_d;
    logic [ACCW-1:0]       a_ext_q [NLANE];
    logic                  accept;
    logic                  lane_clr;
    logic                  lane_add;
    tm_abs_t               abs_w;
    logic [DW-1:0]         wmag;
    logic [NLANE-1:0][TM_MAXW-1:0] ext_w;
    logic                  unused_bits;

    assign abs_w  = tm_abs(TM_MAXW'(in_w), DW, w_signed);
    assign wmag   = abs_w.mag[DW-1:0];
    assign accept = in_valid && in_ready;

    // Only the low ACCW/DW bits of the 64-bit helper results are consumed.
    assign unused_bits = ^{abs_w, ext_w};

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        last_d   = last_q;
        lane_clr = 1'b0;
        lane_add = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    neg_d  = abs_w.neg;
                    last_d = in_last;
                    if (wmag != '0) begin
                        cnt_d   = wmag;
                        state_d = ST_MUL;
                    end else if (in_last) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_MUL: begin
                lane_add = 1'b1;
                cnt_d    = cnt_q - DW'(1);
                if (cnt_q == DW'(1)) begin
                    state_d = last_q ? ST_OUT : ST_IDLE;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    lane_clr = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            last_q  <= last_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
            assign ext_w[gi] = tm_ext(TM_MAXW'(in_a[gi*DW +: DW]), DW, a_signed);

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_ext_q[gi] <= '0;
                end else if (accept) begin
                    a_ext_q[gi] <= ext_w[gi][ACCW-1:0];
                end
            end

            tm_lane #(
                .ACCW(ACCW)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .clr_i    (lane_clr),
                .add_en_i (lane_add),
                .neg_i    (neg_q),
                .a_ext_i  (a_ext_q[gi]),
                .acc_o    (out_acc[gi*ACCW +: ACCW])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tm_mac_seq.sv
// Directed self-checking bench for tm_mac_seq (32-bit and 16-bit accumulator instances).
`timescale 1ns/1ps
module tb_tm_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid16;
    logic        in_ready, in_ready16;
    logic [31:0] in_a;
    logic        a_signed;
    logic [7:0]  in_w;
    logic        w_signed;
    logic        in_last;
    logic        out_valid, out_valid16;
    logic        out_ready;
    logic [127:0] out_acc;
    logic [63:0] out_acc16;
    logic        busy, busy16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tm_mac_seq #(.DW(8), .NLANE(4), .ACCW(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .a_signed(a_signed), .in_w(in_w), .w_signed(w_signed),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .busy(busy)
    );

    tm_mac_seq #(.DW(8), .NLANE(4), .ACCW(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a), .a_signed(a_signed), .in_w(in_w), .w_signed(w_signed),
        .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready),
        .out_acc(out_acc16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [7:0] b0, b1, b2, b3;
        b0 = a0[7:0]; b1 = a1[7:0]; b2 = a2[7:0]; b3 = a3[7:0];
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic signed [31:0] lane(input int i);
        return out_acc[i*32 +: 32];
    endfunction

    function automatic logic signed [15:0] lane16(input int i);
        return out_acc16[i*16 +: 16];
    endfunction

    task automatic run_pair(input logic [31:0] a, input logic asg, input logic [7:0] w,
                            input logic wsg, input logic last, output int edges, output int mulc);
        int guard;
        guard = 0;
        while (!in_ready && guard < 1000) begin
            tick();
            guard++;
        end
        in_a = a; a_signed = asg; in_w = w; w_signed = wsg; in_last = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        edges = 1;
        mulc  = 0;
        while (!(last ? out_valid : in_ready) && edges < 1000) begin
            if (busy) mulc++;
            tick();
            edges++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_lanes(input string tag, input int e0, input int e1, input int e2, input int e3);
        logic signed [31:0] g;
        int exp_v [4];
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        for (int i = 0; i < 4; i++) begin
            g = lane(i);
            check($sformatf("%s_lane%0d", tag, i), 64'(g), 64'(exp_v[i]));
        end
    endtask

    initial begin
        int edges, mulc, guard;
        logic signed [15:0] g16;
        int exp16;

        rst = 1'b1; in_valid = 1'b0; in_valid16 = 1'b0; in_a = '0; a_signed = 1'b0;
        in_w = '0; w_signed = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_acc", out_acc[63:0] | out_acc[127:64], 64'd0);

        // 1: signed A, W=+5
        run_pair(pack4(3, -2, 127, -128), 1'b1, 8'd5, 1'b1, 1'b1, edges, mulc);
        check("t1_mul_cycles", 64'(mulc), 64'd5);
        check("t1_latency", 64'(edges), 64'd6);
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check_lanes("t1", 15, -10, 635, -640);
        handshake();
        check("t1_cleared_valid", 64'(out_valid), 64'd0);
        check("t1_cleared_acc", out_acc[63:0] | out_acc[127:64], 64'd0);

        // 2: W=-128 signed, A=255 unsigned
        run_pair(32'hFFFF_FFFF, 1'b0, 8'h80, 1'b1, 1'b1, edges, mulc);
        check("t2_mul_cycles", 64'(mulc), 64'd128);
        check_lanes("t2", -32640, -32640, -32640, -32640);
        handshake();

        // 3: zero-weight pair then W=2
        run_pair(pack4(7, 7, 7, 7), 1'b1, 8'd0, 1'b1, 1'b0, edges, mulc);
        check("t3_w0_edges", 64'(edges), 64'd1);
        check("t3_w0_mul", 64'(mulc), 64'd0);
        check("t3_w0_in_ready", 64'(in_ready), 64'd1);
        run_pair(pack4(7, 7, 7, 7), 1'b1, 8'd2, 1'b1, 1'b1, edges, mulc);
        check_lanes("t3", 14, 14, 14, 14);
        handshake();

        // 4: output stall, stray in_valid must be ignored
        run_pair(pack4(9, 9, 9, 9), 1'b1, 8'd1, 1'b1, 1'b1, edges, mulc);
        in_a = pack4(50, 50, 50, 50); in_w = 8'd3; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("t4_stall%0d_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("t4_stall%0d_ready", c), 64'(in_ready), 64'd0);
            check($sformatf("t4_stall%0d_acc", c), 64'(lane(0)), 64'd9);
        end
        in_valid = 1'b0;
        handshake();
        run_pair(pack4(4, 4, 4, 4), 1'b1, 8'd1, 1'b1, 1'b1, edges, mulc);
        check_lanes("t4", 4, 4, 4, 4);
        handshake();

        // 5: reset on third MUL cycle
        in_a = pack4(1, 2, 3, 4); a_signed = 1'b1; in_w = 8'd100; w_signed = 1'b1; in_last = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("t5_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_in_ready", 64'(in_ready), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_acc_zero", out_acc[63:0] | out_acc[127:64], 64'd0);
        run_pair(pack4(-5, -5, -5, -5), 1'b1, 8'd3, 1'b1, 1'b1, edges, mulc);
        check("t5_latency", 64'(edges), 64'd4);
        check_lanes("t5", -15, -15, -15, -15);
        handshake();

        // 6: 16-bit accumulator overflow over three pairs
`ifdef TM_SAT_EN
        exp16 = 32767;
`else
        exp16 = -17149;
`endif
        for (int p = 0; p < 3; p++) begin
            in_a = pack4(127, 127, 127, 127); a_signed = 1'b1; in_w = 8'd127; w_signed = 1'b1;
            in_last = (p == 2);
            in_valid16 = 1'b1;
            tick();
            in_valid16 = 1'b0;
            guard = 0;
            while (!((p == 2) ? out_valid16 : in_ready16) && guard < 500) begin
                tick();
                guard++;
            end
        end
        check("t6_out_valid", 64'(out_valid16), 64'd1);
        for (int i = 0; i < 4; i++) begin
            g16 = lane16(i);
            check($sformatf("t6_lane%0d", i), 64'(g16), 64'(exp16));
        end
        handshake();
        check("t6_cleared", out_acc16, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
